// File: rtl/wshb_if.sv
// wshb_if: classic Wishbone bus bundle shared by framebuffer masters and the SDRAM slave.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 32
) ();

    localparam int unsigned DATA_WIDTH = 8 * DATA_BYTES;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_ms;
    logic [DATA_WIDTH-1:0] dat_sm;
    logic [DATA_BYTES-1:0] sel;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/mire.sv
// mire: Wishbone master that writes a grid test pattern into the framebuffer,
// one 32-bit word per pixel in raster order, yielding the bus between bursts.
// Optional feature macro: MIRE_SCROLL_EN (vertical grid lines scroll one pixel per frame).
module mire #(
    parameter int unsigned HDISP        = 800,
    parameter int unsigned VDISP        = 480,
    parameter int unsigned BURST_LEN    = 64,
    parameter int unsigned PAUSE_CYCLES = 1
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    input  logic   enable,
    wshb_if.master wshb_ifm,
    output logic   frame_done,
    output logic   bus_error
);

    localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned PW = $clog2(PAUSE_CYCLES + 1);
    localparam logic [31:0] PIX_ON  = 32'h00FF_FFFF;
    localparam logic [31:0] PIX_OFF = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_PAUSE
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           cyc_q, cyc_d;
    logic           fd_d;
    logic           berr_d;
    logic           last_x, last_y;
    logic [3:0]     col, row;
`ifdef MIRE_SCROLL_EN
    logic [3:0]     off_q, off_d;
`endif
    logic           unused_sigs;

    // rty and read data are not needed: a retried word simply stays presented
    assign unused_sigs = ^{wshb_ifm.rty, wshb_ifm.dat_sm};

    assign wshb_ifm.cyc    = cyc_q;
    assign wshb_ifm.stb    = cyc_q;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.adr    = adr_q;
    assign wshb_ifm.dat_ms = dat_q;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;

    // State, position, burst/pause counters and registered bus outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            adr_q      <= '0;
            dat_q      <= PIX_ON;
            bcnt_q     <= '0;
            pcnt_q     <= '0;
            cyc_q      <= 1'b0;
            frame_done <= 1'b0;
            bus_error  <= 1'b0;
`ifdef MIRE_SCROLL_EN
            off_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            bcnt_q     <= bcnt_d;
            pcnt_q     <= pcnt_d;
            cyc_q      <= cyc_d;
            frame_done <= fd_d;
            bus_error  <= berr_d;
`ifdef MIRE_SCROLL_EN
            off_q      <= off_d;
`endif
        end
    end

    // Next state, raster advance on ack/err, and the pattern for the next word
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        adr_d   = adr_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        fd_d    = 1'b0;
        berr_d  = bus_error;
`ifdef MIRE_SCROLL_EN
        off_d   = off_q;
`endif
        last_x  = (x_q == XW'(HDISP - 1));
        last_y  = (y_q == YW'(VDISP - 1));

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // err counts as an acknowledge: the word is skipped, the error latched
                if (wshb_ifm.ack || wshb_ifm.err) begin
                    berr_d = bus_error | wshb_ifm.err;
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            y_d   = '0;
                            adr_d = '0;
                            fd_d  = 1'b1;
`ifdef MIRE_SCROLL_EN
                            off_d = off_q + 4'd1;
`endif
                        end else begin
                            y_d   = y_q + YW'(1);
                            adr_d = adr_q + WORD_BYTES;
                        end
                    end else begin
                        x_d   = x_q + XW'(1);
                        adr_d = adr_q + WORD_BYTES;
                    end
                    if (bcnt_q == BW'(BURST_LEN - 1)) begin
                        bcnt_d  = '0;
                        pcnt_d  = '0;
                        state_d = S_PAUSE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                        if (!enable) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (pcnt_q == PW'(PAUSE_CYCLES - 1)) begin
                    pcnt_d  = '0;
                    state_d = enable ? S_WRITE : S_IDLE;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cyc_d = (state_d == S_WRITE);

`ifdef MIRE_SCROLL_EN
        col = 4'(x_d) + off_d;
`else
        col = 4'(x_d);
`endif
        row   = 4'(y_d);
        dat_d = ((col == 4'd0) || (row == 4'd0)) ? PIX_ON : PIX_OFF;
    end

endmodule
